p10_prm_writer: RTL and testbench

- Write side of the parameter table. Accepts host write requests (from the command parser) for a parameter address.
- Fetches that parameter's descriptor from p10_rom. Validates the value against the descriptor's rights, min and max.
- Commits accepted values to a register bank and returns a status code.
- Sits between the command/UART parser and the PWM core, which consumes the parallel parameter values.

---
 rtl/p10_prm_writer_if.sv | 69 ++++++
 rtl/p10_prm_writer.sv | 178 +++++++++++++++++
 tb/tb_p10_prm_writer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p10_prm_writer_if.sv
// -----------------------------------------------------------------------------
// p10_prm_pkg / p10_prm_writer_if
//
// Purpose:
//   Shared types for the parameter table and the host write interface of
//   p10_prm_writer.
//   - p10_prm_pkg holds the p10_rom descriptor layout, the response status codes
//     and the well-known slot addresses.
//   - p10_prm_writer_if bundles the write request/response handshake.
//
// Interface signals (the master is the command parser, the slave is p10_prm_writer):
//   wr_req      master->slave  write request, valid with wr_addr/wr_data
//   wr_addr     master->slave  target parameter address ($clog2(PRM_COUNT+1) bits)
//   wr_data     master->slave  value to write (DATA_W bits, unsigned)
//   wr_ready    slave->master  request accepted on wr_req & wr_ready
//   resp_valid  slave->master  one-cycle pulse qualifying resp_status
//   resp_status slave->master  prm_status_e code
// -----------------------------------------------------------------------------
package p10_prm_pkg;
  localparam int PRM_DATA_W = 32;

  typedef enum logic {
    RIGHTS_RO = 1'b0,
    RIGHTS_RW = 1'b1
  } prm_rights_e;

  // Descriptor as registered out of p10_rom.
  typedef struct packed {
    prm_rights_e           rights;
    logic                  is_exec;
    logic [PRM_DATA_W-1:0] min_val;
    logic [PRM_DATA_W-1:0] max_val;
  } prm_entry_t;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_CLAMPED    = 3'd1,
    ST_ERR_ADDR   = 3'd2,
    ST_ERR_RANGE  = 3'd3,
    ST_ERR_RIGHTS = 3'd4
  } prm_status_e;

  localparam int ADDR_FREQ_HZ      = 0;
  localparam int ADDR_DUTY_PERCENT = 1;
endpackage

interface p10_prm_writer_if #(
  parameter int PRM_COUNT = 8,
  parameter int DATA_W    = 32
);
  localparam int AW = $clog2(PRM_COUNT + 1);

  logic              wr_req;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              resp_valid;
  logic [2:0]        resp_status;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ready, resp_valid, resp_status
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ready, resp_valid, resp_status
  );
endinterface

// File: rtl/p10_prm_writer.sv
// -----------------------------------------------------------------------------
// p10_prm_writer
//
// Purpose:
//   Write side of the parameter table.
//   - Accepts a host write, fetches the slot's descriptor from p10_rom and
//     checks it against the descriptor's rights and its min/max range.
//   - Commits an accepted value to the register bank read by the PWM core,
//     then returns a status code.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_if (slave)   write request/response handshake (see p10_prm_writer_if)
//   o_rom_addr      address to p10_rom (held from one valid accept to the next)
//   i_rom_entry     descriptor from p10_rom, registered, 1-cycle latency
//   o_prm_values    flat register bank, slot i at [i*DATA_W +: DATA_W]
//   o_upd_strobe    one-cycle pulse when a value is committed
//   o_upd_addr      address of the committed slot
//   o_exec_strobe   pulses with o_upd_strobe when the entry has is_exec set
//
// Build option:
//   P10_PRM_CLAMP_EN
//   - Defined: out-of-range writes to writable slots are saturated to
//     min/max, committed, and answered with CLAMPED.
//   - Undefined: they are rejected with ERR_RANGE.
// -----------------------------------------------------------------------------
module p10_prm_writer
  import p10_prm_pkg::*;
#(
  parameter  int PRM_COUNT = 8,
  parameter  int DATA_W    = PRM_DATA_W,
  localparam int AW        = $clog2(PRM_COUNT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  p10_prm_writer_if.slave             wr_if,
  output logic [AW-1:0]               o_rom_addr,
  input  prm_entry_t                  i_rom_entry,
  output logic [PRM_COUNT*DATA_W-1:0] o_prm_values,
  output logic                        o_upd_strobe,
  output logic [AW-1:0]               o_upd_addr,
  output logic                        o_exec_strobe
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_RESP} state_e;

  localparam logic [AW-1:0] PRM_COUNT_A = AW'(PRM_COUNT);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW-1:0]     r_req_addr;
  logic [DATA_W-1:0] r_req_data;
  logic [AW-1:0]     r_rom_addr;
  prm_status_e       r_status;
  prm_status_e       w_status_nxt;
  logic              r_resp_valid;
  logic              r_upd_strobe;
  logic              r_exec_strobe;
  logic [AW-1:0]     r_upd_addr;
  logic [DATA_W-1:0] r_bank [PRM_COUNT];

  logic              w_accept;
  logic              w_addr_ok;
  logic              w_commit;
  logic [DATA_W-1:0] w_commit_val;
  logic              w_below;
  logic              w_above;

  // Plain unsigned compares: a full-scale value is never treated as negative.
  assign w_below = (r_req_data < i_rom_entry.min_val);
  assign w_above = (r_req_data > i_rom_entry.max_val);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_accept     = 1'b0;
    w_addr_ok    = 1'b0;
    w_commit     = 1'b0;
    w_commit_val = r_req_data;
    unique case (r_state)
      S_IDLE: begin
        if (wr_if.wr_req) begin
          w_accept = 1'b1;
          if (wr_if.wr_addr >= PRM_COUNT_A) begin
            // No such slot: answer straight away, the ROM is never touched.
            w_status_nxt = ST_ERR_ADDR;
            w_state_nxt  = S_RESP;
          end else begin
            w_addr_ok   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      // The ROM registers the descriptor for o_rom_addr during this cycle.
      S_FETCH: w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_state_nxt = S_RESP;
        if (i_rom_entry.rights == RIGHTS_RO) begin
          w_status_nxt = ST_ERR_RIGHTS;
        end else if (w_below || w_above) begin
`ifdef P10_PRM_CLAMP_EN
          w_commit     = 1'b1;
          w_commit_val = w_below ? i_rom_entry.min_val : i_rom_entry.max_val;
          w_status_nxt = ST_CLAMPED;
`else
          w_status_nxt = ST_ERR_RANGE;
`endif
        end else begin
          w_commit     = 1'b1;
          w_status_nxt = ST_OK;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_addr    <= '0;
      r_req_data    <= '0;
      r_rom_addr    <= '0;
      r_status      <= ST_OK;
      r_resp_valid  <= 1'b0;
      r_upd_strobe  <= 1'b0;
      r_exec_strobe <= 1'b0;
      r_upd_addr    <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr <= wr_if.wr_addr;
        r_req_data <= wr_if.wr_data;
      end
      // Only a valid address reaches the ROM; a rejected one leaves it alone.
      if (w_addr_ok) r_rom_addr <= wr_if.wr_addr;
      r_status      <= w_status_nxt;
      // Registered on the edge leaving RESP, so the pulse coincides with the
      // first IDLE cycle and a new request may be accepted alongside it.
      r_resp_valid  <= (r_state == S_RESP);
      r_upd_strobe  <= w_commit;
      r_exec_strobe <= w_commit && i_rom_entry.is_exec;
      if (w_commit) r_upd_addr <= r_req_addr;
    end
  end

  // NOTE: the bank is a small flop array (the PWM core reads every slot in
  // parallel), so it can be, and is, reset to zero like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PRM_COUNT; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < PRM_COUNT; i++) begin
        if (w_commit && (r_req_addr == AW'(i))) r_bank[i] <= w_commit_val;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PRM_COUNT; i++) o_prm_values[i*DATA_W +: DATA_W] = r_bank[i];
  end

  assign wr_if.wr_ready    = (r_state == S_IDLE);
  assign wr_if.resp_valid  = r_resp_valid;
  assign wr_if.resp_status = r_status;
  assign o_rom_addr        = r_rom_addr;
  assign o_upd_strobe      = r_upd_strobe;
  assign o_upd_addr        = r_upd_addr;
  assign o_exec_strobe     = r_exec_strobe;

endmodule

// File: tb/tb_p10_prm_writer.sv
// -----------------------------------------------------------------------------
// tb_p10_prm_writer
//
// Bench for p10_prm_writer.
// - Stands in for p10_rom with a registered descriptor table that the
//   stimulus may rewrite between requests.
// - Holds a transaction-level model of the write side: each accepted request
//   is resolved to a status, an optional commit and a response time counted in
//   clock edges from the accept edge.
// - A compare process checks every cycle's outputs against that model, and the
//   directed stimulus pins the model with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_p10_prm_writer;
  import p10_prm_pkg::*;

  localparam int PRM_COUNT = 8;
  localparam int DATA_W    = 32;
  localparam int AW        = $clog2(PRM_COUNT + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p10_prm_writer_if #(.PRM_COUNT(PRM_COUNT), .DATA_W(DATA_W)) wr_if ();

  logic [AW-1:0]               rom_addr;
  logic [AW-1:0]               upd_addr;
  prm_entry_t                  rom_q = '0;
  logic [PRM_COUNT*DATA_W-1:0] prm_flat;
  logic                        upd_strobe;
  logic                        exec_strobe;

  p10_prm_writer #(.PRM_COUNT(PRM_COUNT), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_if        (wr_if.slave),
    .o_rom_addr   (rom_addr),
    .i_rom_entry  (rom_q),
    .o_prm_values (prm_flat),
    .o_upd_strobe (upd_strobe),
    .o_upd_addr   (upd_addr),
    .o_exec_strobe(exec_strobe)
  );

  // ROM stand-in: registered, one cycle of latency.
  prm_entry_t rom_tbl [PRM_COUNT];
  always @(posedge clk)
    rom_q <= (int'(rom_addr) < PRM_COUNT) ? rom_tbl[int'(rom_addr)] : '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] slot(input int i);
    return prm_flat[i*DATA_W +: DATA_W];
  endfunction

  // ---------------- transaction model ----------------
  int                m_cyc = 0;     // index of the most recent rising edge
  bit                m_pend = 1'b0;
  int                m_acc  = 0;    // edge index of the accept
  int                m_lat  = 0;    // edges from accept to the response cycle
  bit                m_commit, m_exec;
  logic [AW-1:0]     m_addr;
  logic [DATA_W-1:0] m_val;
  logic [2:0]        m_status;
  logic [AW-1:0]     m_rom_addr = '0;
  logic [DATA_W-1:0] m_bank [PRM_COUNT];

  task automatic model_accept(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    prm_entry_t e;
    m_pend   = 1'b1;
    m_acc    = m_cyc;
    m_addr   = a;
    m_val    = d;
    m_commit = 1'b0;
    m_exec   = 1'b0;
    if (int'(a) >= PRM_COUNT) begin
      m_status = 3'd2;
      m_lat    = 1;
    end else begin
      e          = rom_tbl[int'(a)];
      m_lat      = 3;
      m_rom_addr = a;
      if (e.rights == RIGHTS_RO) begin
        m_status = 3'd4;
      end else if (d < e.min_val || d > e.max_val) begin
`ifdef P10_PRM_CLAMP_EN
        m_status = 3'd1;
        m_commit = 1'b1;
        m_val    = (d < e.min_val) ? e.min_val : e.max_val;
`else
        m_status = 3'd3;
`endif
      end else begin
        m_status = 3'd0;
        m_commit = 1'b1;
      end
      m_exec = m_commit && e.is_exec;
    end
  endtask

  // Accepts are sampled on the rising edge, outputs compared on the falling one.
  initial begin
    int  k;
    bit  exp_upd, exp_resp, exp_ready;
    for (int i = 0; i < PRM_COUNT; i++) m_bank[i] = '0;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (rst_n && wr_if.wr_req && wr_if.wr_ready) model_accept(wr_if.wr_addr, wr_if.wr_data);
      @(negedge clk);
      if (!rst_n) begin
        m_pend     = 1'b0;
        m_rom_addr = '0;
        for (int i = 0; i < PRM_COUNT; i++) m_bank[i] = '0;
        check("rst_resp_valid", wr_if.resp_valid, 0);
        check("rst_upd_strobe", upd_strobe, 0);
        check("rst_prm_values", (prm_flat == '0), 1);
        check("rst_rom_addr", rom_addr, 0);
      end else begin
        k         = m_cyc - m_acc;
        exp_upd   = m_pend && m_commit && (k == 2);
        exp_resp  = m_pend && (k == m_lat);
        exp_ready = !(m_pend && (k < m_lat));
        if (exp_upd) m_bank[int'(m_addr)] = m_val;
        check("cyc_wr_ready", wr_if.wr_ready, exp_ready);
        check("cyc_resp_valid", wr_if.resp_valid, exp_resp);
        if (exp_resp) check("cyc_resp_status", wr_if.resp_status, m_status);
        check("cyc_upd_strobe", upd_strobe, exp_upd);
        check("cyc_exec_strobe", exec_strobe, exp_upd && m_exec);
        if (exp_upd) check("cyc_upd_addr", upd_addr, m_addr);
        check("cyc_rom_addr", rom_addr, m_rom_addr);
        for (int i = 0; i < PRM_COUNT; i++) check($sformatf("cyc_slot%0d", i), slot(i), m_bank[i]);
        if (m_pend && k >= m_lat) m_pend = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [2:0]    t_status;
  int            t_edges, t_upd, t_exec, t_both, t_low;
  logic [AW-1:0] t_upd_addr;

  task automatic do_write(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    bit acc, got;
    #1;
    wr_if.wr_req  = 1'b1;
    wr_if.wr_addr = a;
    wr_if.wr_data = d;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(posedge clk);
      acc = wr_if.wr_ready;
    end
    #1 wr_if.wr_req = 1'b0;
    t_status = 3'h7; t_edges = 0; t_upd = 0; t_exec = 0; t_both = 0; t_low = 0;
    t_upd_addr = '0;
    if (!acc) begin
      check("accept_timeout", 0, 1);
      return;
    end
    got = 1'b0;
    while (!got && t_edges < 12) begin
      @(negedge clk);
      if (!wr_if.wr_ready) t_low++;
      if (upd_strobe) begin t_upd++; t_upd_addr = upd_addr; end
      if (exec_strobe) t_exec++;
      if (upd_strobe && exec_strobe) t_both++;
      if (wr_if.resp_valid) begin
        got = 1'b1;
        t_status = wr_if.resp_status;
      end else begin
        @(posedge clk);
        t_edges++;
      end
    end
    if (!got) check("resp_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < PRM_COUNT; i++) rom_tbl[i] = '{RIGHTS_RW, 1'b0, 32'd0, 32'd100};
    rom_tbl[ADDR_FREQ_HZ]      = '{RIGHTS_RW, 1'b0, 32'd0, 32'd1_000_000};
    rom_tbl[ADDR_DUTY_PERCENT] = '{RIGHTS_RW, 1'b0, 32'd0, 32'd50};
    rom_tbl[4] = '{RIGHTS_RW, 1'b0, 32'd0, 32'hFFFF_FFFF};
    rom_tbl[5] = '{RIGHTS_RW, 1'b0, 32'd7, 32'd7};
    rom_tbl[6] = '{RIGHTS_RW, 1'b0, 32'd10, 32'd20};
    wr_if.wr_req  = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_wr_ready", wr_if.wr_ready, 1);
    check("reset_resp_status", wr_if.resp_status, 0);
    check("reset_upd_addr", upd_addr, 0);

    // Reset while the first request sits in FETCH: it must vanish silently.
    @(posedge clk);
    #1;
    wr_if.wr_req  = 1'b1;
    wr_if.wr_addr = AW'(ADDR_DUTY_PERCENT);
    wr_if.wr_data = 32'd20;
    @(posedge clk);
    #1;
    wr_if.wr_req = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      int n_resp = 0;
      repeat (6) begin
        @(negedge clk);
        if (wr_if.resp_valid) n_resp++;
      end
      check("midrst_no_resp", n_resp, 0);
    end
    check("midrst_duty_slot", slot(ADDR_DUTY_PERCENT), 0);
    check("midrst_wr_ready", wr_if.wr_ready, 1);

    do_write(AW'(ADDR_DUTY_PERCENT), 32'd40);
    check("duty40_status", t_status, 0);
    check("duty40_latency_edges", t_edges, 3);
    check("duty40_ready_low_cycles", t_low, 3);
    check("duty40_upd_count", t_upd, 1);
    check("duty40_upd_addr", t_upd_addr, ADDR_DUTY_PERCENT);
    check("duty40_exec_count", t_exec, 0);
    check("duty40_slot", slot(ADDR_DUTY_PERCENT), 40);

    do_write(AW'(ADDR_DUTY_PERCENT), 32'd51);
`ifdef P10_PRM_CLAMP_EN
    check("duty51_status", t_status, 1);
    check("duty51_slot", slot(ADDR_DUTY_PERCENT), 50);
    check("duty51_upd_count", t_upd, 1);
`else
    check("duty51_status", t_status, 3);
    check("duty51_slot", slot(ADDR_DUTY_PERCENT), 40);
    check("duty51_upd_count", t_upd, 0);
`endif

    // Back-to-back: the second request is raised the moment the first answers.
    do_write(AW'(ADDR_FREQ_HZ), 32'd500_000);
    check("freq_a_status", t_status, 0);
    check("freq_a_slot", slot(ADDR_FREQ_HZ), 500_000);
    do_write(AW'(ADDR_FREQ_HZ), 32'd0);
    check("freq_b_status", t_status, 0);
    check("freq_b_ready_low_cycles", t_low, 3);
    check("freq_b_slot", slot(ADDR_FREQ_HZ), 0);

    // min == max: only the exact value passes.
    do_write(AW'(5), 32'd7);
    check("eq_exact_status", t_status, 0);
    do_write(AW'(5), 32'd8);
`ifdef P10_PRM_CLAMP_EN
    check("eq_above_status", t_status, 1);
`else
    check("eq_above_status", t_status, 3);
`endif
    do_write(AW'(5), 32'd6);
`ifdef P10_PRM_CLAMP_EN
    check("eq_below_status", t_status, 1);
`else
    check("eq_below_status", t_status, 3);
`endif
    check("eq_slot", slot(5), 7);

    // Rewriting an identical value is still a commit.
    do_write(AW'(5), 32'd7);
    check("same_value_status", t_status, 0);
    check("same_value_upd_count", t_upd, 1);

    // Out-of-table addresses: no ROM access, no commit, answered after edge 1.
    do_write(AW'(8), 32'd5);
    check("addr8_status", t_status, 2);
    check("addr8_latency_edges", t_edges, 1);
    check("addr8_ready_low_cycles", t_low, 1);
    check("addr8_upd_count", t_upd, 0);
    check("addr8_rom_addr", rom_addr, 5);
    do_write(AW'(15), 32'd1);
    check("addr15_status", t_status, 2);

    // Read-only descriptor is refused before any range test.
    rom_tbl[2] = '{RIGHTS_RO, 1'b0, 32'd0, 32'd100};
    do_write(AW'(2), 32'd3);
    check("ro_status", t_status, 4);
    check("ro_upd_count", t_upd, 0);
    check("ro_slot", slot(2), 0);

    // Exec descriptor: both strobes in the same cycle.
    rom_tbl[3] = '{RIGHTS_RW, 1'b1, 32'd0, 32'd1};
    do_write(AW'(3), 32'd1);
    check("exec_status", t_status, 0);
    check("exec_both_same_cycle", t_both, 1);
    check("exec_count", t_exec, 1);

    // Full-scale values stay unsigned.
    do_write(AW'(4), 32'hFFFF_FFFF);
    check("fullscale_status", t_status, 0);
    check("fullscale_slot", slot(4), 32'hFFFF_FFFF);
    do_write(AW'(7), 32'h8000_0000);
`ifdef P10_PRM_CLAMP_EN
    check("msb_set_status", t_status, 1);
    check("msb_set_slot", slot(7), 100);
`else
    check("msb_set_status", t_status, 3);
    check("msb_set_slot", slot(7), 0);
`endif

    // Range edges of a 10..20 slot.
    do_write(AW'(6), 32'd10);
    check("lo_edge_status", t_status, 0);
    do_write(AW'(6), 32'd20);
    check("hi_edge_status", t_status, 0);
    do_write(AW'(6), 32'd9);
`ifdef P10_PRM_CLAMP_EN
    check("lo_out_status", t_status, 1);
    check("lo_out_slot", slot(6), 10);
`else
    check("lo_out_status", t_status, 3);
    check("lo_out_slot", slot(6), 20);
`endif
    do_write(AW'(6), 32'd21);
`ifdef P10_PRM_CLAMP_EN
    check("hi_out_status", t_status, 1);
`else
    check("hi_out_status", t_status, 3);
`endif
    check("hi_out_slot", slot(6), 20);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
